lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, the number of 32-bit words in the attached data memory.
REQ-002 SHALL have ports, one per line, as follows:
  clk  in  1  single clock, all state on rising edge
  rst  in  1  asynchronous, active-high reset
  req_valid  in  1  core access request
  req_ready  out  1  high only in IDLE
  req_we  in  1  1=store, 0=load
  req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
  req_unsigned  in  1  load zero-extend (1) / sign-extend (0)
  req_addr  in  32  byte address
  req_wdata  in  32  store data, right-aligned
  resp_valid  out  1  one-cycle completion pulse
  resp_rdata  out  32  extended load data; 0 for stores and errors
  resp_err  out  1  misaligned, illegal size or out-of-range access
  mem_we  out  1  data-memory write enable
  mem_a  out  32  data-memory byte address, word-aligned (bits [1:0]=0)
  mem_wd  out  32  data-memory write word
  mem_rd  in  32  data-memory read word, valid one clk after mem_a is presented (registered read, read-before-write)

Function
REQ-003 SHALL accept a request on a rising edge with req_valid && req_ready and latch all req_* fields.
REQ-004 SHALL implement FSM states IDLE, RD, RDW, WR, RESP.
REQ-005 IDLE->RESP on accept if erroneous; IDLE->WR for a legal word store; IDLE->RD for a legal load or sub-word store.
REQ-006 RD: mem_a=latched word address, mem_we=0; RD->RDW unconditionally.
REQ-007 RDW: mem_rd is valid; a load registers the extracted/extended data and goes RDW->RESP; a sub-word store registers the merged word and goes RDW->WR.
REQ-008 WR: mem_we=1 for exactly one cycle, with mem_a and mem_wd set; WR->RESP.
REQ-009 RESP: resp_valid=1 for one cycle with resp_rdata and resp_err; RESP->IDLE; there is no resp back-pressure.
REQ-010 Latency from accept edge to the resp_valid cycle SHALL be: error 1, word store 2, load 3, sub-word store 4.
REQ-011 Error conditions: size=11; half with addr[0]=1; word with addr[1:0]!=0; addr[31:2] >= DEPTH_WORDS.
REQ-012 An errored access SHALL never assert mem_we or present a new mem_a read.
REQ-013 Lane selection is little-endian: a byte uses lane addr[1:0]; a half uses lane addr[1].
REQ-014 A sub-word store SHALL replace only the addressed lane(s) of the read word, taking the data from req_wdata[7:0] or req_wdata[15:0]; the other lanes are preserved.
REQ-015 Loads SHALL extend to 32 bits per req_unsigned; for a word load req_unsigned is ignored.
REQ-016 Outside WR, mem_we SHALL be 0 and mem_wd SHALL hold the last registered value.
REQ-017 A new request SHALL be accepted no earlier than the cycle after RESP, since req_ready=0 outside IDLE.

Reset
REQ-018 rst SHALL immediately force state=IDLE, mem_we=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_a=0, mem_wd=0 and all latched request fields to 0.
REQ-019 A reset asserted mid-access SHALL drop the request with no response; a partially completed RMW SHALL leave memory either untouched or fully written, never half-merged.
REQ-020 After rst deasserts, req_ready SHALL be 1 on the first clk.

Structure
REQ-021 Package lsu_pkg SHALL hold the FSM state encoding, the size encodings (SZ_B, SZ_H, SZ_W) and DEPTH_WORDS_DEF=64.
REQ-022 Sub-module lsu_align SHALL be combinational and provide both the load extract/extend path and the store lane-merge path; lsu_ctrl instantiates it once.

Verification
REQ-023 The bench SHALL model the data memory as 64 words with registered read and read-before-write, preloaded with mem[4]=0x11223344.
REQ-024 Byte store of 0xAB to 0x12 -> mem[4]=0x11AB3344; resp_valid 4 cycles after accept; resp_err=0.
REQ-025 Signed byte load at 0x12 -> resp_rdata=0xFFFFFFAB; unsigned half load at 0x12 -> 0x000011AB; latency 3.
REQ-026 Word store 0xDEADBEEF to 0x10, then word load from 0x10 -> 0xDEADBEEF; store latency 2, exactly one mem_we pulse.
REQ-027 Half load at 0x13, word at 0x102, size=11, and any access at 0x100 -> resp_err=1, resp_rdata=0, latency 1, mem_we never asserted.
REQ-028 rst pulsed during RDW of a half store to 0x10 -> no resp_valid, mem[4] unchanged, req_ready=1 on the first clk after release.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg -- shared definitions for the load/store unit controller.
//   state_t          : controller FSM state encoding
//   SZ_B/SZ_H/SZ_W   : req_size encodings (SZ_X is the illegal code)
//   DEPTH_WORDS_DEF  : default data-memory depth in 32-bit words
//   access_err()     : error rule shared by accept-time and latched checks
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    RDW  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  localparam int DEPTH_WORDS_DEF = 64;

  // An access is erroneous when the size code is illegal, the address is
  // misaligned for its size, or the word index falls outside the memory.
  function automatic logic access_err(input logic [1:0]  size,
                                      input logic [31:0] addr,
                                      input logic [31:0] depth);
    logic e;
    e = 1'b0;
    case (size)
      SZ_B:    e = 1'b0;
      SZ_H:    e = addr[0];
      SZ_W:    e = |addr[1:0];
      default: e = 1'b1;
    endcase
    if ({2'b00, addr[31:2]} >= depth) e = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align -- combinational lane logic for the load/store unit.
//   size         in  2   access size code
//   load_unsigned in 1   zero-extend (1) / sign-extend (0) sub-word loads
//   lane         in  2   byte address bits [1:0]
//   rd_word      in  32  word read from the data memory
//   wdata        in  32  right-aligned store data
//   load_data    out 32  extracted and extended load value
//   merged_word  out 32  rd_word with the addressed lane(s) replaced by wdata
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [1:0]  lane,
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  // Little-endian: a byte lives at bit 8*lane, a half at bit 16*lane[1].
  logic [4:0]  b_shamt;
  logic [4:0]  h_shamt;
  logic [31:0] b_shifted;
  logic [31:0] h_shifted;

  assign b_shamt   = {lane, 3'b000};
  assign h_shamt   = {lane[1], 4'b0000};
  assign b_shifted = rd_word >> b_shamt;
  assign h_shifted = rd_word >> h_shamt;

  always_comb begin
    load_data   = rd_word;
    merged_word = wdata;
    case (size)
      SZ_B: begin
        load_data   = {{24{~load_unsigned & b_shifted[7]}}, b_shifted[7:0]};
        merged_word = (rd_word & ~(32'h0000_00FF << b_shamt))
                    | ({24'h0, wdata[7:0]} << b_shamt);
      end
      SZ_H: begin
        load_data   = {{16{~load_unsigned & h_shifted[15]}}, h_shifted[15:0]};
        merged_word = (rd_word & ~(32'h0000_FFFF << h_shamt))
                    | ({16'h0, wdata[15:0]} << h_shamt);
      end
      default: begin
        // Word accesses pass straight through; illegal sizes never reach
        // the memory so their value here is irrelevant.
        load_data   = rd_word;
        merged_word = wdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl -- single-outstanding load/store controller for a word-wide
// data memory with a one-cycle registered read.
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_we, req_size, req_unsigned, req_addr, req_wdata  request fields
//   resp_valid, resp_rdata, resp_err  one-cycle response pulse
//   mem_we, mem_a, mem_wd, mem_rd     data-memory port
// Sub-word stores are done as read-modify-write: RD -> RDW -> WR.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

  state_t      state;
  state_t      state_next;

  logic        we_reg;
  logic [1:0]  size_reg;
  logic        uns_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] rdata_reg;
  logic [31:0] mem_a_reg;
  logic [31:0] mem_wd_reg;

  logic        accept;
  logic        req_err;
  logic        held_err;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  assign accept   = req_valid && (state == IDLE);
  assign req_err  = access_err(req_size, req_addr, DEPTH_L);
  // The latched request carries its own error status, so no separate
  // error flag needs to be stored.
  assign held_err = access_err(size_reg, addr_reg, DEPTH_L);

  lsu_align u_align (
    .size          (size_reg),
    .load_unsigned (uns_reg),
    .lane          (addr_reg[1:0]),
    .rd_word       (mem_rd),
    .wdata         (wdata_reg),
    .load_data     (load_data),
    .merged_word   (merged_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err)                          state_next = RESP;
          else if (req_we && req_size == SZ_W)  state_next = WR;
          else                                  state_next = RD;
        end
      end
      RD:      state_next = RDW;
      RDW:     state_next = we_reg ? WR : RESP;
      WR:      state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_reg     <= 1'b0;
      size_reg   <= 2'b00;
      uns_reg    <= 1'b0;
      addr_reg   <= 32'h0;
      wdata_reg  <= 32'h0;
      rdata_reg  <= 32'h0;
      mem_a_reg  <= 32'h0;
      mem_wd_reg <= 32'h0;
    end else begin
      if (accept) begin
        we_reg    <= req_we;
        size_reg  <= req_size;
        uns_reg   <= req_unsigned;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
        rdata_reg <= 32'h0;
        // Errored accesses leave the memory address untouched so no new
        // read is presented for them.
        if (!req_err) begin
          mem_a_reg <= {req_addr[31:2], 2'b00};
          if (req_we && req_size == SZ_W) mem_wd_reg <= req_wdata;
        end
      end
      if (state == RDW) begin
        if (we_reg) mem_wd_reg <= merged_word;
        else        rdata_reg  <= load_data;
      end
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_err   = (state == RESP) && held_err;
  assign resp_rdata = rdata_reg;
  assign mem_we     = (state == WR);
  assign mem_a      = mem_a_reg;
  assign mem_wd     = mem_wd_reg;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl -- scoreboard bench for lsu_ctrl. A byte-array reference
// model predicts each response; a negedge monitor pops and compares.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  localparam int DW = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  lsu_ctrl #(.DEPTH_WORDS(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Attached data memory: registered read, read-before-write.
  logic [31:0] mem [DW];
  logic [31:0] init_words [DW];
  logic        load_mem = 1'b1;

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < DW; i++) mem[i] <= init_words[i];
    end else if (mem_we) begin
      mem[mem_a[7:2]] <= mem_wd;
    end
    mem_rd <= mem[mem_a[7:2]];
  end

  // Reference model state.
  logic [7:0]  ref_bytes [4*DW];
  logic [31:0] ref_last_a = 32'h0;
  int          exp_writes = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic [31:0] a;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Cycle bookkeeping for latency and outstanding-request tracking.
  int cyc_cnt = 0, acc_cyc = 0, acc_cnt = 0, resp_cnt = 0, drop_cnt = 0, we_cnt = 0;

  always @(posedge clk) begin
    cyc_cnt++;
    if (rst) begin
      if (acc_cnt != resp_cnt + drop_cnt) drop_cnt = acc_cnt - resp_cnt;
    end else if (req_valid && req_ready) begin
      acc_cnt++;
      acc_cyc = cyc_cnt;
    end
    if (mem_we) we_cnt++;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (resp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_resp", {31'b0, resp_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          $display("resp: rdata=%08h err=%0d lat=%0d (exp %08h %0d %0d)",
                   resp_rdata, resp_err, cyc_cnt - acc_cyc + 1, e.rdata, e.err, e.lat);
          chk("rdata", resp_rdata, e.rdata);
          chk("err", {31'b0, resp_err}, {31'b0, e.err});
          chk("latency", 32'(cyc_cnt - acc_cyc + 1), 32'(e.lat));
          chk("mem_a", mem_a, e.a);
        end
        resp_cnt++;
      end else if (acc_cnt != resp_cnt + drop_cnt) begin
        chk("ready_while_busy", {31'b0, req_ready}, 32'd0);
      end
    end
  end

  // Model: expected response computed from byte-addressed memory rules.
  function automatic exp_t predict(input logic we, input logic [1:0] size, input logic uns,
                                   input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    logic err;
    logic [31:0] v;
    int n;
    int base;
    err = (size == 2'b11) || (size == SZ_H && addr[0]) ||
          (size == SZ_W && addr[1:0] != 2'b00) || ((addr >> 2) >= DW);
    n = 1 << size;
    if (err) begin
      e.rdata = 32'h0; e.err = 1'b1; e.lat = 1; e.a = ref_last_a;
    end else begin
      base = int'(addr[7:0]);
      ref_last_a = {addr[31:2], 2'b00};
      e.a = ref_last_a;
      e.err = 1'b0;
      if (we) begin
        for (int i = 0; i < n; i++) ref_bytes[base + i] = wdata[8*i +: 8];
        exp_writes++;
        e.rdata = 32'h0;
        e.lat = (n == 4) ? 2 : 4;
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_bytes[base + i];
        if (!uns && n < 4 && v[8*n-1])
          for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
        e.rdata = v;
        e.lat = 3;
      end
    end
    return e;
  endfunction

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input bit model);
    bit got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (req_ready) got = 1;
    end
    if (!got) begin
      chk("ready_timeout", {31'b0, req_ready}, 32'd1);
    end else begin
      if (model) sb.push_back(predict(we, size, uns, addr, wdata));
      req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  int w0;

  initial begin
    for (int i = 0; i < DW; i++) init_words[i] = $urandom;
    init_words[4] = 32'h1122_3344;
    for (int i = 0; i < DW; i++)
      for (int b = 0; b < 4; b++) ref_bytes[4*i + b] = init_words[i][8*b +: 8];

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    load_mem = 1'b0;
    @(negedge clk);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);
    rst = 1'b0;
    #1 chk("ready_after_rst", {31'b0, req_ready}, 32'd1);

    // Byte store then loads of the same location.
    issue(1'b1, SZ_B, 1'b0, 32'h12, 32'h0000_00AB, 1'b1);
    drain();
    chk("byte_store_mem4", mem[4], 32'h11AB_3344);
    issue(1'b0, SZ_B, 1'b0, 32'h12, 32'h0, 1'b1);
    issue(1'b0, SZ_H, 1'b1, 32'h12, 32'h0, 1'b1);
    drain();

    // Word store / load with exactly one write pulse.
    w0 = we_cnt;
    issue(1'b1, SZ_W, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b1);
    drain();
    chk("word_store_pulses", 32'(we_cnt - w0), 32'd1);
    chk("word_store_mem4", mem[4], 32'hDEAD_BEEF);
    issue(1'b0, SZ_W, 1'b1, 32'h10, 32'h0, 1'b1);
    drain();

    // Error cases never write.
    w0 = we_cnt;
    issue(1'b0, SZ_H, 1'b0, 32'h13, 32'h0, 1'b1);
    issue(1'b0, SZ_W, 1'b0, 32'h102, 32'h0, 1'b1);
    issue(1'b1, 2'b11, 1'b0, 32'h20, 32'h5555_5555, 1'b1);
    issue(1'b0, SZ_B, 1'b0, 32'h100, 32'h0, 1'b1);
    issue(1'b1, SZ_B, 1'b0, 32'h100, 32'h77, 1'b1);
    issue(1'b1, SZ_W, 1'b0, 32'h8000_0000, 32'h1, 1'b1);
    drain();
    chk("err_no_write", 32'(we_cnt - w0), 32'd0);

    // Reset during the RDW cycle of a half store.
    issue(1'b1, SZ_H, 1'b0, 32'h10, 32'h0000_5555, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("midrst_mem_a", mem_a, 32'd0);
    chk("midrst_mem_wd", mem_wd, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ref_last_a = 32'h0;
    #1 chk("midrst_ready", {31'b0, req_ready}, 32'd1);
    repeat (6) @(negedge clk);
    chk("midrst_mem4", mem[4], 32'hDEAD_BEEF);

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      logic [31:0] a;
      int r;
      r = $urandom_range(0, 9);
      if (r < 8)       a = 32'($urandom_range(0, 255));
      else if (r == 8) a = 32'($urandom_range(256, 300));
      else             a = $urandom;
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            a, $urandom, 1'b1);
    end
    drain();

    chk("total_writes", 32'(we_cnt), 32'(exp_writes));
    for (int i = 0; i < DW; i++)
      chk("final_mem", mem[i], {ref_bytes[4*i+3], ref_bytes[4*i+2], ref_bytes[4*i+1], ref_bytes[4*i]});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
